// File: rtl/ef_spi_arb_pkg.sv
// Shared types and helpers for the SPI transfer arbiter: FSM states, counter
// width and the select-index width function.
package ef_spi_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_XFER,
    S_WAIT,
    S_HOLD,
    S_GAP
  } arb_state_t;

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned CNT_MAX = 255;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ef_spi_rr_arbiter.sv
// Combinational round-robin picker: first set request after rr_ptr, with
// wrap-around, so the previous winner has lowest priority.
module ef_spi_rr_arbiter
  import ef_spi_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned SELW = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [SELW-1:0] rr_ptr,
  output logic [NREQ-1:0] gnt,
  output logic [SELW-1:0] gnt_idx
);

  logic            found;
  logic [SELW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = SELW'((32'(rr_ptr) + 32'd1 + i) % NREQ);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/ef_spi_xfer_arbiter.sv
// Shares one SPI byte engine between NREQ requesters: round-robin grant held
// for a chip-select framed transaction with setup/hold/gap and stall timeout.
module ef_spi_xfer_arbiter
  import ef_spi_arb_pkg::*;
#(
  parameter int unsigned NREQ     = 2,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned CS_GAP   = 4,
  parameter int unsigned IDLE_TO  = 255,
  localparam int unsigned SELW    = sel_width(NREQ)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NREQ-1:0]   req_i,
  output logic [NREQ-1:0]   gnt_o,
  input  logic [NREQ-1:0]   tx_valid_i,
  input  logic [8*NREQ-1:0] tx_data_i,
  input  logic [NREQ-1:0]   last_i,
  output logic [NREQ-1:0]   tx_ready_o,
  output logic [7:0]        rx_data_o,
  output logic [NREQ-1:0]   rx_valid_o,
  output logic              ss_n_o,
  output logic [SELW-1:0]   ss_sel_o,
  output logic              eng_start_o,
  output logic [7:0]        eng_data_o,
  input  logic              eng_busy_i,
  input  logic              eng_done_i,
  input  logic [7:0]        eng_data_i,
  output logic              busy_o,
  output logic              err_o
);

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("ef_spi_xfer_arbiter: NREQ must be 2..8");
  end
  if (CS_SETUP > CNT_MAX || CS_HOLD > CNT_MAX || CS_GAP > CNT_MAX || IDLE_TO > CNT_MAX) begin : g_bad_cnt
    $error("ef_spi_xfer_arbiter: timing parameters must not exceed 255");
  end

  localparam logic [CNT_W-1:0] SETUP_LIM = CNT_W'((CS_SETUP == 0) ? 0 : CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LIM  = CNT_W'((CS_HOLD  == 0) ? 0 : CS_HOLD  - 1);
  localparam logic [CNT_W-1:0] GAP_LIM   = CNT_W'((CS_GAP   == 0) ? 0 : CS_GAP   - 1);
  localparam logic [CNT_W-1:0] TO_LIM    = CNT_W'((IDLE_TO  == 0) ? 0 : IDLE_TO  - 1);

  // Zero-length phases are skipped by choosing the successor state up front.
  localparam arb_state_t AFTER_GRANT = (CS_SETUP != 0) ? S_SETUP : S_XFER;
  localparam arb_state_t AFTER_HOLD  = (CS_GAP   != 0) ? S_GAP   : S_IDLE;
  localparam arb_state_t AFTER_XFER  = (CS_HOLD  != 0) ? S_HOLD  : AFTER_HOLD;

  arb_state_t       state, state_nxt;
  logic [CNT_W-1:0] ph_cnt, to_cnt;
  logic [SELW-1:0]  rr_ptr;
  logic             last_q;
  logic [NREQ-1:0]  arb_gnt;
  logic [SELW-1:0]  arb_idx;
  logic             valid_g, last_g;
  logic [7:0]       data_g;
  logic             hs, take, release_cs, to_hit;

  ef_spi_rr_arbiter #(
    .NREQ (NREQ),
    .SELW (SELW)
  ) u_rr (
    .req     (req_i),
    .rr_ptr  (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  always_comb begin
    valid_g = 1'b0;
    last_g  = 1'b0;
    data_g  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (ss_sel_o == SELW'(i)) begin
        valid_g = tx_valid_i[i];
        last_g  = last_i[i];
        data_g  = tx_data_i[8*i +: 8];
      end
    end
  end

  assign hs          = (state == S_XFER) && !eng_busy_i && valid_g;
  assign to_hit      = (IDLE_TO != 0) && (state == S_XFER) && !valid_g && (to_cnt == TO_LIM);
  assign tx_ready_o  = ((state == S_XFER) && !eng_busy_i) ? gnt_o : '0;
  assign eng_start_o = hs;
  assign eng_data_o  = hs ? data_g : '0;
  assign busy_o      = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    case (state)
      S_IDLE: begin
        if (|req_i) begin
          take      = 1'b1;
          state_nxt = AFTER_GRANT;
        end
      end
      S_SETUP: if (ph_cnt == SETUP_LIM) state_nxt = S_XFER;
      S_XFER: begin
        if (hs)          state_nxt = S_WAIT;
        else if (to_hit) state_nxt = AFTER_XFER;
      end
      S_WAIT:  if (eng_done_i) state_nxt = last_q ? AFTER_XFER : S_XFER;
      S_HOLD:  if (ph_cnt == HOLD_LIM) state_nxt = AFTER_HOLD;
      S_GAP:   if (ph_cnt == GAP_LIM) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    release_cs = (state != S_IDLE) && (state != S_GAP) &&
                 ((state_nxt == S_IDLE) || (state_nxt == S_GAP));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      ph_cnt     <= '0;
      to_cnt     <= '0;
      rr_ptr     <= SELW'(NREQ - 1);
      gnt_o      <= '0;
      ss_sel_o   <= '0;
      ss_n_o     <= 1'b1;
      last_q     <= 1'b0;
      rx_data_o  <= '0;
      rx_valid_o <= '0;
      err_o      <= 1'b0;
    end else begin
      state  <= state_nxt;
      ph_cnt <= (state_nxt != state) ? '0 : ph_cnt + CNT_W'(1);
      if (take || to_hit || hs || ((state == S_XFER) && valid_g)) to_cnt <= '0;
      else if (state == S_XFER)                                  to_cnt <= to_cnt + CNT_W'(1);
      if (take) begin
        gnt_o    <= arb_gnt;
        ss_sel_o <= arb_idx;
        rr_ptr   <= arb_idx;
        ss_n_o   <= 1'b0;
      end else if (release_cs) begin
        gnt_o  <= '0;
        ss_n_o <= 1'b1;
      end
      if (hs) last_q <= last_g;
      rx_valid_o <= '0;
      if ((state == S_WAIT) && eng_done_i) begin
        rx_data_o  <= eng_data_i;
        rx_valid_o <= gnt_o;
      end
      err_o <= to_hit;
    end
  end

endmodule

// File: doc/ef_spi_xfer_arbiter.md
Name: ef_spi_xfer_arbiter

Overview:
- Shares one SPI master byte engine (shift register plus sclk generator) between NREQ requesters.
- Round-robin arbitration; a grant is held for a whole chip-select-framed transaction of one or more bytes.
- Sequences chip select with programmable setup, hold and inter-transaction gap, and aborts a stalled requester on timeout.
- Sits between requester ports (bus wrappers, DMA) and the byte engine that drives mosi, miso and sclk.

Parameters:
- NREQ, 2, number of requesters (2..8).
- CS_SETUP, 2, clk_i cycles with ss_n_o low before the first byte starts (0 allowed).
- CS_HOLD, 2, clk_i cycles with ss_n_o low after the last byte completes (0 allowed).
- CS_GAP, 4, minimum clk_i cycles with ss_n_o high between transactions (0 allowed).
- IDLE_TO, 255, cycles a granted requester may leave tx_valid_i low mid-transaction before abort; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- req_i  in  NREQ  per-requester transaction request
- gnt_o  out  NREQ  one-hot grant, held for the whole transaction
- tx_valid_i  in  NREQ  byte valid, per requester
- tx_data_i  in  8*NREQ  byte to send; requester k uses bits [8k+7:8k]
- last_i  in  NREQ  qualifies the byte as the final byte of the transaction
- tx_ready_o  out  NREQ  byte accepted when valid and ready are both high
- rx_data_o  out  8  received byte, shared by all requesters
- rx_valid_o  out  NREQ  1-cycle pulse to the granted requester only
- ss_n_o  out  1  chip select, active-low
- ss_sel_o  out  SELW  index of the granted requester; SELW = max(1, clog2(NREQ))
- eng_start_o  out  1  1-cycle pulse that starts one byte in the engine
- eng_data_o  out  8  byte presented to the engine, valid with eng_start_o
- eng_busy_i  in  1  engine busy shifting
- eng_done_i  in  1  1-cycle pulse when the engine finishes a byte
- eng_data_i  in  8  received byte, valid with eng_done_i
- busy_o  out  1  state != IDLE
- err_o  out  1  1-cycle pulse on timeout abort

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE, ss_n_o=1, every other output 0.
  - rr_ptr=NREQ-1, so requester 0 wins the first arbitration.
- States: IDLE, SETUP, XFER, WAIT, HOLD, GAP.
- IDLE:
  - If |req_i, the winner is the first set bit searching from rr_ptr+1 with wrap-around.
  - Next cycle: gnt_o one-hot, ss_sel_o = winner, ss_n_o=0, rr_ptr = winner.
  - Next state is SETUP, or XFER if CS_SETUP=0.
  - Latency from req_i to gnt_o/ss_n_o is exactly 1 cycle.
- SETUP: counts CS_SETUP cycles, then XFER.
- XFER:
  - tx_ready_o[g] = !eng_busy_i; all other ready bits are 0.
  - On a handshake, eng_start_o pulses in the same cycle (combinational) and eng_data_o = tx_data of g.
  - last_i[g] is latched and state goes to WAIT.
  - tx_valid of non-granted requesters is ignored.
- WAIT:
  - On eng_done_i: rx_data_o <= eng_data_i and rx_valid_o[g] pulses on the following cycle.
  - Next state is HOLD if the latched last=1, else XFER.
  - rx_data_o holds its value until the next done.
- Timeout:
  - In XFER, the counter increments while tx_valid_i[g]=0 and clears on valid.
  - When the count reaches IDLE_TO (nonzero): err_o pulses and state goes to HOLD with no start issued.
  - The counter does not run in SETUP, WAIT, HOLD or GAP.
- HOLD: counts CS_HOLD cycles. On exit, ss_n_o=1, gnt_o=0 and state goes to GAP.
- GAP: counts CS_GAP cycles, then IDLE. Requests are re-arbitrated only in IDLE.
- Deasserting req_i mid-transaction has no effect; only last or timeout ends a transaction.
- A zero-valued CS_* parameter skips its state entirely (0 extra cycles).
- eng_done_i outside WAIT is ignored. eng_start_o is never asserted while eng_busy_i=1.
- Simultaneous requests: the round-robin order decides; the previous winner has lowest priority.
- A requester holding req_i continuously is re-granted only after every other active requester has been served once.
- Counters are 8 bits; parameters above 255 are illegal (elaboration assertion).

Decomposition:
- Package ef_spi_arb_pkg holds:
  - state enum (IDLE, SETUP, XFER, WAIT, HOLD, GAP);
  - counter width constant (8);
  - selection-width function.
- Sub-module ef_spi_rr_arbiter (parameter NREQ): inputs req and rr_ptr; outputs a combinational one-hot grant and its index.

Test Plan:
- Single-byte transaction: req_i=01, tx 0xA5 with last=1, engine returns 0x3C.
  - gnt_o=01 and ss_n_o=0 at +1.
  - eng_start_o 2 cycles after SETUP begins, with eng_data_o=0xA5.
  - rx_valid_o=01 with rx_data_o=0x3C.
  - ss_n_o high after 2 HOLD cycles; busy_o low after 4 GAP cycles.
- Multi-byte transaction: requester 1 sends 0x01,0x02,0x03 (last on 0x03).
  - ss_n_o low continuously across all 3 bytes.
  - Three rx_valid_o[1] pulses.
  - ss_sel_o=1 throughout.
- Round-robin fairness: req_i=11 held for 4 transactions → grant order 0,1,0,1; no back-to-back grant to the same requester.
- Timeout: IDLE_TO=10, grantee sends one non-last byte then stalls.
  - err_o pulses 10 cycles into XFER.
  - No further eng_start_o; ss_n_o high after HOLD.
- Engine busy backpressure: eng_busy_i held high 20 cycles while tx_valid_i=1.
  - tx_ready_o=0 and no eng_start_o during those cycles.
  - Start occurs in the first cycle busy is low.
- Async reset mid-WAIT: rst_i pulsed → immediately ss_n_o=1, gnt_o=0, busy_o=0; first grant after release goes to requester 0.
